// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and execute-stage state encoding shared by the exec stage
// and its multiplier.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } exec_state_t;

endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: shift-add unsigned multiplier. It runs for exactly XLEN cycles after
// i_start and then pulses o_done for one cycle. o_prod holds the low XLEN bits.
module alu_iter_mul #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_prod
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;

  // One multiplier bit per cycle, with no early-out on a zero multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_abort) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= CNT_W'(XLEN - 1);
      r_run    <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_run) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == '0) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage with a registered result and valid/ready handshakes.
// Define ALU_EXEC_MUL_EN to make code 100 an iterative multiply. Without it, code 100 is an ADD.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_ctrl,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic [REG_AW-1:0] rd_out
);

  exec_state_t       r_state;
  exec_state_t       w_state_nxt;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   w_alu_res;
  logic              w_accept;
  logic              w_complete;
  logic              w_is_mul;
  logic              w_mul_done;

  assign in_ready   = rst_n && (r_state == IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = r_out_valid && out_ready;

`ifdef ALU_EXEC_MUL_EN
  logic              w_start_mul;
  logic [XLEN-1:0]   w_mul_prod;
  logic [REG_AW-1:0] r_mul_rd;

  assign w_is_mul    = (alu_ctrl == ALU_MUL);
  assign w_start_mul = w_accept && w_is_mul;

  alu_iter_mul #(
    .XLEN (XLEN)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start_mul),
    .i_abort (flush),
    .i_a     (op_a),
    .i_b     (op_b),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  // The multiply's destination register must outlive the accept cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mul_rd <= '0;
    end else if (w_start_mul) begin
      r_mul_rd <= rd_in;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
`endif

  // Single-cycle datapath. Reserved codes fall back to ADD.
  always_comb begin
    w_alu_res = op_a + op_b;
    case (alu_ctrl)
      ALU_ADD: w_alu_res = op_a + op_b;
      ALU_SUB: w_alu_res = op_a - op_b;
      ALU_AND: w_alu_res = op_a & op_b;
      ALU_OR:  w_alu_res = op_a | op_b;
      default: w_alu_res = op_a + op_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && w_is_mul) w_state_nxt = BUSY;
      BUSY: if (flush || w_mul_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output register. Flush wins; zero is derived from the value being loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_rd        <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_res;
      r_zero      <= (w_alu_res == '0);
      r_rd        <= rd_in;
`ifdef ALU_EXEC_MUL_EN
    end else if ((r_state == BUSY) && w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_prod;
      r_zero      <= (w_mul_prod == '0);
      r_rd        <= r_mul_rd;
`endif
    end else if (w_complete) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign rd_out    = r_rd;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks of alu_exec_stage against a behavioural model.
// The multiply checks are built when ALU_EXEC_MUL_EN is defined.
module tb_alu_exec_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_ctrl;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [REG_AW-1:0] rd_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              zero;
  logic [REG_AW-1:0] rd_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .rd_out    (rd_out)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
`ifdef ALU_EXEC_MUL_EN
      3'd4: return 32'(64'(a) * 64'(b));
`endif
      default: return a + b;
    endcase
  endfunction

  task automatic drive_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    rd_in    = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    alu_ctrl = 3'd0; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd3;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || rd_out !== 5'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b r=%h z=%b rd=%0d want 0/0/0/0", out_valid, result, zero, rd_out);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    logic [2:0]  c [7];
    logic [31:0] a [7];
    logic [31:0] b [7];
    logic [4:0]  rd[7];
    logic [31:0] e [7];
    c[0] = 3'd0; a[0] = 32'hFFFF_FFFF; b[0] = 32'h1;         rd[0] = 5'd5;  e[0] = 32'h0;
    c[1] = 3'd1; a[1] = 32'd5;         b[1] = 32'd7;         rd[1] = 5'd1;  e[1] = 32'hFFFF_FFFE;
    c[2] = 3'd2; a[2] = 32'hF0F0;      b[2] = 32'h0FF0;      rd[2] = 5'd2;  e[2] = 32'h00F0;
    c[3] = 3'd3; a[3] = 32'hA000;      b[3] = 32'h000B;      rd[3] = 5'd3;  e[3] = 32'hA00B;
    c[4] = 3'd5; a[4] = 32'd10;        b[4] = 32'd20;        rd[4] = 5'd4;  e[4] = 32'd30;
    c[5] = 3'd7; a[5] = 32'hFFFF_FFFF; b[5] = 32'hFFFF_FFFF; rd[5] = 5'd31; e[5] = 32'hFFFF_FFFE;
`ifdef ALU_EXEC_MUL_EN
    c[6] = 3'd6; a[6] = 32'd1;         b[6] = 32'd2;         rd[6] = 5'd6;  e[6] = 32'd3;
`else
    c[6] = 3'd4; a[6] = 32'd7;         b[6] = 32'd6;         rd[6] = 5'd6;  e[6] = 32'd13;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_op(c[i], a[i], b[i], rd[i]);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL ops_ready[%0d] got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== e[i] || zero !== (e[i] == 32'd0) || rd_out !== rd[i]) begin
        bad++;
        $display("FAIL ops[%0d] got v=%b r=%h z=%b rd=%0d want 1/%h/%b/%0d",
                 i, out_valid, result, zero, rd_out, e[i], (e[i] == 32'd0), rd[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive_op(3'd0, 32'h100, 32'h23, 5'd9);
    @(posedge clk); #1;
    drive_op(3'd1, 32'd50, 32'd8, 5'd10);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== 32'h123 || zero !== 1'b0 || rd_out !== 5'd9) begin
        bad++;
        $display("FAIL stall_hold[%0d] got v=%b r=%h rd=%0d want 1/123/9", i, out_valid, result, rd_out);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd42 || rd_out !== 5'd10) begin
      bad++;
      $display("FAIL stall_next got v=%b r=%h rd=%0d want 1/2a/10", out_valid, result, rd_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  c;
    logic [31:0] a, b, e;
    logic [4:0]  rd;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom; rd = 5'(i + 20);
      e = ref_alu(c, a, b);
      drive_op(c, a, b, rd);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || result !== e || rd_out !== rd) begin
        bad++;
        $display("FAIL b2b[%0d] got v=%b r=%h rd=%0d want 1/%h/%0d", i, out_valid, result, rd_out, e, rd);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_op(3'd3, 32'd1, 32'd2, 5'd7);
    @(posedge clk); #1;
    flush = 1'b1;
    drive_op(3'd0, 32'd3, 32'd4, 5'd8);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got %b want 0", out_valid); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_noaccept got %b want 0", out_valid); end
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul();
    logic [31:0] a, b, e;
    int n;
    bit seen;
    out_ready = 1'b1; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 32'd7 : 32'($urandom);
      b = (k == 0) ? 32'd6 : ((k == 1) ? 32'd0 : 32'($urandom));
      e = ref_alu(3'd4, a, b);
      drive_op(3'd4, a, b, 5'(12 + k));
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_busy_ready[%0d] got %b want 0", k, in_ready); end
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (out_valid !== 1'b1 && n < 100);
      total++;
      if (n != 33 || result !== e || zero !== (e == 32'd0) || rd_out !== 5'(12 + k)) begin
        bad++;
        $display("FAIL mul[%0d] got lat=%0d r=%h rd=%0d want 33/%h/%0d", k, n, result, rd_out, e, 12 + k);
      end
      @(posedge clk); #1;
    end
    drive_op(3'd4, 32'd7, 32'd6, 5'd15);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_flush_idle got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL mul_flush_noresult got 1 want 0"); end
    drive_op(3'd4, 32'd3, 32'd3, 5'd16);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    total++;
    if (seen || in_ready !== 1'b1) begin
      bad++; $display("FAIL mul_reset got seen=%b ready=%b want 0/1", seen, in_ready);
    end
  endtask
`endif

  task automatic test_random();
    exp_t q[$];
    exp_t x;
    logic [2:0] c;
    logic exp_ready;
    for (int i = 0; i < 300; i++) begin
      c = 3'($urandom_range(0, 7));
`ifdef ALU_EXEC_MUL_EN
      if (c == 3'd4) c = 3'd0;
`endif
      drive_op(c, $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 7) == 0) begin alu_ctrl = 3'd1; op_b = op_a; end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      exp_ready = !flush && (q.size() == 0 || out_ready);
      total++;
      if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, exp_ready); end
      x.res = ref_alu(alu_ctrl, op_a, op_b);
      x.rd  = rd_in;
      @(posedge clk); #1;
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) q.push_back(x);
      end
      total++;
      if (out_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, (q.size() != 0));
      end else if (q.size() != 0) begin
        total++;
        if (result !== q[0].res || zero !== (q[0].res == 32'd0) || rd_out !== q[0].rd) begin
          bad++;
          $display("FAIL rnd_data[%0d] got r=%h z=%b rd=%0d want %h/%b/%0d",
                   i, result, zero, rd_out, q[0].res, (q[0].res == 32'd0), q[0].rd);
        end
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_stall();
    test_back_to_back();
    test_flush();
`ifdef ALU_EXEC_MUL_EN
    test_mul();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
